// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: measures incoming frame geometry and sequences multi-frame
// captures, emitting expanded pixels, a pixel-valid qualifier and frame-boundary strobes.
module frame_capture_ctrl #(
  parameter int FRAMES_W = 8
) (
  input  logic                pclk,
  input  logic                rst_n,
  input  logic                hblnk,
  input  logic                vblnk,
  input  logic [11:0]         rgb_in,
  input  logic                cap_req,
  input  logic [FRAMES_W-1:0] cap_frames,
  output logic [7:0]          r,
  output logic [7:0]          g,
  output logic [7:0]          b,
  output logic                pix_valid,
  output logic                go,
  output logic [15:0]         xdim,
  output logic [15:0]         ydim,
  output logic                busy,
  output logic                done,
  output logic                dim_err
);
  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPT, FINISH} state_t;
  state_t r_state, w_nxt;
  logic r_hb, r_vb, r_act, r_sof_seen, r_meas_ok, r_first, r_go, r_done, r_dim_err;
  logic [15:0] r_pcnt, r_line_w, r_lines, r_meas_x, r_meas_y, r_xdim, r_ydim;
  logic [FRAMES_W-1:0] r_fl;
  logic [7:0] r_r, r_g, r_b;
  logic w_act, w_sof, w_eof, w_hend, w_go, w_done, w_take;
  logic [15:0] w_lw, w_ln;
  assign w_act  = ~hblnk & ~vblnk;
  assign w_sof  = r_vb & ~vblnk;
  assign w_eof  = ~r_vb & vblnk;
  assign w_hend = ~r_hb & hblnk & (r_pcnt != 16'd0);
  // a line ending in the same cycle as EOF still counts toward this frame
  assign w_lw   = w_hend ? r_pcnt : r_line_w;
  assign w_ln   = (w_hend && r_lines != 16'hFFFF) ? r_lines + 16'd1 : r_lines;
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_hb       <= 1'b0;
      r_vb       <= 1'b0;
      r_act      <= 1'b0;
      r_sof_seen <= 1'b0;
      r_meas_ok  <= 1'b0;
      r_pcnt     <= '0;
      r_line_w   <= '0;
      r_lines    <= '0;
      r_meas_x   <= '0;
      r_meas_y   <= '0;
      r_r        <= '0;
      r_g        <= '0;
      r_b        <= '0;
    end else begin
      r_hb  <= hblnk;
      r_vb  <= vblnk;
      r_act <= w_act;
      r_r   <= {rgb_in[11:8], rgb_in[11:8]};
      r_g   <= {rgb_in[7:4], rgb_in[7:4]};
      r_b   <= {rgb_in[3:0], rgb_in[3:0]};
      if (w_sof) r_sof_seen <= 1'b1;
      if (w_eof) begin
        r_pcnt   <= '0;
        r_line_w <= '0;
        r_lines  <= '0;
        // only a frame that began after reset is trusted as a measurement
        if (r_sof_seen) begin
          r_meas_x  <= w_lw;
          r_meas_y  <= w_ln;
          r_meas_ok <= 1'b1;
        end
      end else if (w_hend) begin
        r_line_w <= r_pcnt;
        r_lines  <= w_ln;
        r_pcnt   <= '0;
      end else if (w_act && r_pcnt != 16'hFFFF) begin
        r_pcnt <= r_pcnt + 16'd1;
      end
    end
  end
  always_comb begin
    w_nxt  = r_state;
    w_go   = 1'b0;
    w_done = 1'b0;
    w_take = 1'b0;
    case (r_state)
      IDLE: begin
        w_take = cap_req;
        w_nxt  = cap_req ? WAIT_SOF : IDLE;
      end
      WAIT_SOF: begin
        w_go  = w_sof & r_meas_ok;
        w_nxt = w_go ? CAPT : WAIT_SOF;
      end
      CAPT: begin
        w_done = w_eof & (r_fl == FRAMES_W'(1));
        w_go   = w_done;
        w_nxt  = w_eof ? (w_done ? FINISH : WAIT_SOF) : CAPT;
      end
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_go      <= 1'b0;
      r_done    <= 1'b0;
      r_fl      <= '0;
      r_first   <= 1'b0;
      r_dim_err <= 1'b0;
      r_xdim    <= '0;
      r_ydim    <= '0;
    end else begin
      r_state <= w_nxt;
      r_go    <= w_go;
      r_done  <= w_done;
      if (w_take) begin
        r_fl      <= (cap_frames == '0) ? FRAMES_W'(1) : cap_frames;
        r_dim_err <= 1'b0;
        r_first   <= 1'b1;
      end
      // geometry is frozen by the first captured frame of a request
      if (r_state == WAIT_SOF && w_go && r_first) begin
        r_xdim  <= r_meas_x;
        r_ydim  <= r_meas_y;
        r_first <= 1'b0;
      end
      if (r_state == CAPT && w_eof) begin
        r_fl <= r_fl - FRAMES_W'(1);
        if (w_lw != r_xdim || w_ln != r_ydim) r_dim_err <= 1'b1;
      end
    end
  end
  assign r         = r_r;
  assign g         = r_g;
  assign b         = r_b;
  assign pix_valid = r_act & (r_state == CAPT);
  assign go        = r_go;
  assign done      = r_done;
  assign busy      = r_state != IDLE;
  assign xdim      = r_xdim;
  assign ydim      = r_ydim;
  assign dim_err   = r_dim_err;
endmodule
